// File: rtl/sram_alloc_arb_pkg.sv
// Shared types and constants for the SRAM block allocator/arbiter.
package sram_alloc_arb_pkg;

    localparam int unsigned CNT_W      = 12;
    localparam int unsigned BANK_DEPTH = 2048;

    typedef logic [4:0] sram_id_t;

    typedef enum logic [1:0] {
        StIdle,
        StAlloc,
        StStall
    } state_e;

endpackage

// File: rtl/sram_alloc_arb_rr_pick.sv
// Round-robin picker: first set bit of vec_i at or above ptr_i, wrapping to bit 0.
module rr_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    vec_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    onehot_o,
    output logic [IdxW-1:0] idx_o,
    output logic            found_o
);

    int unsigned j;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        found_o  = 1'b0;
        j        = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr_i) + i) % N;
            if (!found_o && vec_i[j]) begin
                found_o     = 1'b1;
                onehot_o[j] = 1'b1;
                idx_o       = IdxW'(j);
            end
        end
    end

endmodule

// File: rtl/sram_alloc_arb.sv
// Arbitrates requesters for free blocks held in a pool of SRAM banks; tracks per-bank free counts.
module sram_alloc_arb
    import sram_alloc_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned NUM_SRAM   = 4,
    parameter int unsigned BANK_DEPTH = sram_alloc_arb_pkg::BANK_DEPTH,
    localparam int unsigned ReqW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned BankW = (NUM_SRAM > 1) ? $clog2(NUM_SRAM) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    output logic               alloc_valid,
    output logic [ReqW-1:0]    alloc_req_id,
    output logic [4:0]         alloc_sram_id,
    input  logic               release_valid,
    input  logic [4:0]         release_sram_id,
    output logic               pool_empty,
    output logic               release_err
);

    state_e               state_q, state_d;
    logic [ReqW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [BankW-1:0]     bank_ptr_q, bank_ptr_d;
    logic [CNT_W-1:0]     cnt_q [NUM_SRAM];
    logic [CNT_W-1:0]     cnt_d [NUM_SRAM];
    logic [ReqW-1:0]      alloc_req_id_q, alloc_req_id_d;
    sram_id_t             alloc_sram_id_q, alloc_sram_id_d;
    logic                 pool_empty_q, pool_empty_d;
    logic                 release_err_q, release_err_d;

    logic [NUM_REQ-1:0]   req_onehot;
    logic [ReqW-1:0]      req_idx;
    logic                 req_any;
    logic [NUM_SRAM-1:0]  bank_nz, bank_onehot;
    logic [BankW-1:0]     bank_idx;
    logic                 bank_any;
    logic [NUM_SRAM-1:0]  dec_vec, inc_vec;
    logic                 grant, rel_in_range, rel_full, rel_ok;

    always_comb begin
        bank_nz = '0;
        for (int b = 0; b < NUM_SRAM; b++) begin
            bank_nz[b] = (cnt_q[b] != '0);
        end
    end

    rr_pick #(.N(NUM_REQ)) u_req_pick (
        .vec_i    (req_valid),
        .ptr_i    (rr_ptr_q),
        .onehot_o (req_onehot),
        .idx_o    (req_idx),
        .found_o  (req_any)
    );

    rr_pick #(.N(NUM_SRAM)) u_bank_pick (
        .vec_i    (bank_nz),
        .ptr_i    (bank_ptr_q),
        .onehot_o (bank_onehot),
        .idx_o    (bank_idx),
        .found_o  (bank_any)
    );

    // Grant decision uses pre-edge counters, so a same-cycle release cannot unblock it.
    assign grant     = rst_n && (state_q == StIdle) && req_any && bank_any;
    assign req_ready = grant ? req_onehot : '0;

    always_comb begin
        rel_in_range = (int'(release_sram_id) < NUM_SRAM);
        rel_full     = rel_in_range &&
                       (cnt_q[release_sram_id[BankW-1:0]] == CNT_W'(BANK_DEPTH));
        rel_ok       = release_valid && rel_in_range && !rel_full;
    end

    always_comb begin
        dec_vec = grant ? bank_onehot : '0;
        inc_vec = '0;
        for (int b = 0; b < NUM_SRAM; b++) begin
            inc_vec[b] = rel_ok && (release_sram_id == sram_id_t'(b));
        end
    end

    always_comb begin
        pool_empty_d = 1'b1;
        for (int b = 0; b < NUM_SRAM; b++) begin
            cnt_d[b] = cnt_q[b];
            if (inc_vec[b] && !dec_vec[b]) begin
                cnt_d[b] = cnt_q[b] + 1'b1;
            end else if (dec_vec[b] && !inc_vec[b]) begin
                cnt_d[b] = cnt_q[b] - 1'b1;
            end
            if (cnt_d[b] != '0) begin
                pool_empty_d = 1'b0;
            end
        end
        release_err_d = release_err_q || (release_valid && !rel_ok);
    end

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        bank_ptr_d      = bank_ptr_q;
        alloc_req_id_d  = alloc_req_id_q;
        alloc_sram_id_d = alloc_sram_id_q;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d         = StAlloc;
                    alloc_req_id_d  = req_idx;
                    alloc_sram_id_d = sram_id_t'(bank_idx);
                    rr_ptr_d   = (int'(req_idx) == NUM_REQ - 1) ? '0 : req_idx + 1'b1;
                    bank_ptr_d = (int'(bank_idx) == NUM_SRAM - 1) ? '0 : bank_idx + 1'b1;
                end else if (req_any && !bank_any) begin
                    state_d = StStall;
                end
            end
            StAlloc: state_d = StIdle;
            StStall: begin
                if (!pool_empty_d) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            rr_ptr_q        <= '0;
            bank_ptr_q      <= '0;
            alloc_req_id_q  <= '0;
            alloc_sram_id_q <= '0;
            pool_empty_q    <= 1'b0;
            release_err_q   <= 1'b0;
            for (int b = 0; b < NUM_SRAM; b++) begin
                cnt_q[b] <= CNT_W'(BANK_DEPTH);
            end
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            bank_ptr_q      <= bank_ptr_d;
            alloc_req_id_q  <= alloc_req_id_d;
            alloc_sram_id_q <= alloc_sram_id_d;
            pool_empty_q    <= pool_empty_d;
            release_err_q   <= release_err_d;
            for (int b = 0; b < NUM_SRAM; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
        end
    end

    assign alloc_valid   = (state_q == StAlloc);
    assign alloc_req_id  = alloc_req_id_q;
    assign alloc_sram_id = alloc_sram_id_q;
    assign pool_empty    = pool_empty_q;
    assign release_err   = release_err_q;

endmodule
